// File: rtl/telemetry_decoder.sv
// telemetry_decoder: parses AA 55 framed BATT/TORQUE/CURR telemetry bytes from UART_rcv
module telemetry_decoder #(
    parameter logic [7:0] HDR1        = 8'hAA,
    parameter logic [7:0] HDR2        = 8'h55,
    parameter int         TIMEOUT_CYC = 200000,
    parameter int         ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rdy,
    output logic             clr_rdy,
    output logic [11:0]      batt,
    output logic [11:0]      torque,
    output logic [11:0]      curr,
    output logic             pkt_vld,
    output logic             in_frame,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {SYNC1, SYNC2, PAYLOAD} state_t;
    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [5:0][7:0] shd_q, shd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [11:0] batt_q, batt_d, torque_q, torque_d, curr_q, curr_d;
    logic vld_q, vld_d, clr_q, clr_d, err_inc;
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shd_d    = shd_q;
        timer_d  = timer_q;
        batt_d   = batt_q;
        torque_d = torque_q;
        curr_d   = curr_q;
        vld_d    = 1'b0;
        clr_d    = rdy;
        err_inc  = 1'b0;
        if (rdy) begin
            timer_d = '0;
            case (state_q)
                SYNC1: state_d = (rx_data == HDR1) ? SYNC2 : SYNC1;
                SYNC2: begin
                    state_d = (rx_data == HDR2) ? PAYLOAD : (rx_data == HDR1) ? SYNC2 : SYNC1;
                    idx_d   = '0;
                end
                PAYLOAD: begin
                    if (!idx_q[0] && rx_data[7:4] != 4'h0) begin
                        state_d = SYNC1;
                        err_inc = 1'b1;
                    end else if (idx_q == 3'd5) begin
                        state_d  = SYNC1;
                        batt_d   = {shd_q[0][3:0], shd_q[1]};
                        torque_d = {shd_q[2][3:0], shd_q[3]};
                        curr_d   = {shd_q[4][3:0], rx_data};
                        vld_d    = 1'b1;
                    end else begin
                        shd_d[idx_q] = rx_data;
                        idx_d        = idx_q + 3'd1;
                    end
                end
                default: state_d = SYNC1;
            endcase
        end else if (state_q != SYNC1) begin
            // A byte landing on the expiry cycle takes the rdy branch above instead
            if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = SYNC1;
                timer_d = '0;
                err_inc = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
        err_d = (err_inc && err_q != '1) ? err_q + 1'b1 : err_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SYNC1;
            idx_q    <= '0;
            shd_q    <= '0;
            timer_q  <= '0;
            err_q    <= '0;
            batt_q   <= '0;
            torque_q <= '0;
            curr_q   <= '0;
            vld_q    <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shd_q    <= shd_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            batt_q   <= batt_d;
            torque_q <= torque_d;
            curr_q   <= curr_d;
            vld_q    <= vld_d;
            clr_q    <= clr_d;
        end
    end
    assign clr_rdy  = clr_q;
    assign batt     = batt_q;
    assign torque   = torque_q;
    assign curr     = curr_q;
    assign pkt_vld  = vld_q;
    assign in_frame = state_q != SYNC1;
    assign err_cnt  = err_q;
endmodule
